// File: rtl/rej_uniform_sampler.sv
// -----------------------------------------------------------------------------
// rej_uniform_sampler
//
// Kyber rejection sampler (Parse). Takes the SHAKE128 output string of the
// matrix-seed sponge path and emits one polynomial's N uniform coefficients
// in [0, Q-1] as a registered stream. One 12-bit candidate is evaluated per
// cycle.
//
// Because of the Kyber byte packing, candidate i is simply
// in_string[12i+11:12i]. The whole string is captured into a shift register
// when a run starts. During RUN the register shifts right by 12 bits every
// cycle, so the current candidate is always the low 12 bits.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   enable       start request, sampled only in IDLE
//   in_string    sponge output, captured at the IDLE->RUN edge only
//   coeff_valid  one-cycle pulse per accepted coefficient
//   coeff        accepted coefficient value (holds between pulses)
//   coeff_index  position 0..N-1 of coeff in the polynomial
//   busy         high while in RUN
//   done         high while in DONE
//   fail         high in DONE when the input ran out before N accepts
// -----------------------------------------------------------------------------
module rej_uniform_sampler #(
    parameter int Q       = 3329,
    parameter int N       = 256,
    parameter int IN_BITS = 5376
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [IN_BITS-1:0] in_string,
    output logic               coeff_valid,
    output logic [11:0]        coeff,
    output logic [7:0]         coeff_index,
    output logic               busy,
    output logic               done,
    output logic               fail
);

    localparam int          NUM_CAND  = IN_BITS / 12;
    localparam logic [11:0] Q_LIM     = 12'(Q);
    localparam logic [8:0]  N_LIM     = 9'(N);
    localparam logic [8:0]  N_LAST    = 9'(N - 1);
    localparam logic [8:0]  LAST_CAND = 9'(NUM_CAND - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [IN_BITS-1:0] shreg_reg;
    logic [IN_BITS-1:0] shreg_shifted;
    logic [8:0]         cand_cnt_reg;
    logic [8:0]         acc_cnt_reg;
    logic               coeff_valid_reg;
    logic [11:0]        coeff_reg;
    logic [7:0]         coeff_index_reg;
    logic               fail_reg;

    logic [11:0] cand;
    logic        accept;
    logic        nth_accept;
    logic        last_cand;
    logic        start;

    assign cand       = shreg_reg[11:0];
    assign start      = (state_reg == IDLE) && enable;
    assign accept     = (state_reg == RUN) && (cand < Q_LIM) && (acc_cnt_reg < N_LIM);
    assign nth_accept = accept && (acc_cnt_reg == N_LAST);
    assign last_cand  = (cand_cnt_reg == LAST_CAND);

    // Shift by one 12-bit lane: lane gi takes lane gi+1, top lane fills with 0.
    for (genvar gi = 0; gi < NUM_CAND; gi++) begin : g_lane
        if (gi < NUM_CAND - 1) begin : g_mid
            assign shreg_shifted[12*gi +: 12] = shreg_reg[12*(gi+1) +: 12];
        end else begin : g_top
            assign shreg_shifted[12*gi +: 12] = 12'd0;
        end
    end

    // The candidate store is always loaded before it is read, so it carries
    // no reset.
    always_ff @(posedge clk) begin
        if (start) begin
            shreg_reg <= in_string;
        end else if (state_reg == RUN) begin
            shreg_reg <= shreg_shifted;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic. The N-th accept wins over input exhaustion so that a
    // final candidate that completes the polynomial ends with fail=0.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (enable) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (nth_accept || last_cand) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // Held-high enable keeps us here so a run never retriggers.
                if (!enable) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: counters and registered output stream
    always_ff @(posedge clk) begin
        if (rst) begin
            cand_cnt_reg    <= '0;
            acc_cnt_reg     <= '0;
            coeff_valid_reg <= 1'b0;
            coeff_reg       <= '0;
            coeff_index_reg <= '0;
            fail_reg        <= 1'b0;
        end else begin
            coeff_valid_reg <= accept;
            if (accept) begin
                coeff_reg       <= cand;
                coeff_index_reg <= acc_cnt_reg[7:0];
                acc_cnt_reg     <= acc_cnt_reg + 9'd1;
            end
            case (state_reg)
                IDLE: begin
                    if (enable) begin
                        cand_cnt_reg <= '0;
                        acc_cnt_reg  <= '0;
                        fail_reg     <= 1'b0;
                    end
                end
                RUN: begin
                    cand_cnt_reg <= cand_cnt_reg + 9'd1;
                    if (last_cand && !nth_accept) begin
                        fail_reg <= 1'b1;
                    end
                end
                DONE: begin
                    if (!enable) begin
                        fail_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign coeff_valid = coeff_valid_reg;
    assign coeff       = coeff_reg;
    assign coeff_index = coeff_index_reg;
    assign busy        = (state_reg == RUN);
    assign done        = (state_reg == DONE);
    assign fail        = fail_reg;

endmodule

// File: tb/tb_rej_uniform_sampler.sv
// -----------------------------------------------------------------------------
// tb_rej_uniform_sampler
//
// Directed bench for rej_uniform_sampler. Each step drives inputs just after
// a rising edge and checks outputs 1 time unit after the following edge.
// E0 denotes the edge at which enable is first sampled high in IDLE.
// -----------------------------------------------------------------------------
module tb_rej_uniform_sampler;

    localparam int IN_BITS = 5376;

    logic               clk = 1'b0;
    logic               rst;
    logic               enable;
    logic [IN_BITS-1:0] in_string;
    logic               coeff_valid;
    logic [11:0]        coeff;
    logic [7:0]         coeff_index;
    logic               busy;
    logic               done;
    logic               fail;

    int n_checks = 0;
    int n_fail   = 0;
    int vcnt;
    int bcnt;

    rej_uniform_sampler #(
        .Q       (3329),
        .N       (256),
        .IN_BITS (IN_BITS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .in_string   (in_string),
        .coeff_valid (coeff_valid),
        .coeff       (coeff),
        .coeff_index (coeff_index),
        .busy        (busy),
        .done        (done),
        .fail        (fail)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        enable    = 1'b0;
        in_string = '0;
        tick();
        tick();
        chk("rst_valid", 32'(coeff_valid), 0);
        chk("rst_coeff", 32'(coeff), 0);
        chk("rst_index", 32'(coeff_index), 0);
        chk("rst_busy",  32'(busy), 0);
        chk("rst_done",  32'(done), 0);
        chk("rst_fail",  32'(fail), 0);
        rst = 1'b0;
        tick();

        // ---- all-zero input: 256 consecutive accepts of 0 ----
        in_string = '0;
        enable    = 1'b1;
        tick();                                   // E0
        enable    = 1'b0;
        chk("zero_busy_e0",  32'(busy), 1);
        chk("zero_valid_e0", 32'(coeff_valid), 0);
        for (int k = 1; k <= 256; k++) begin
            tick();
            chk("zero_valid", 32'(coeff_valid), 1);
            chk("zero_coeff", 32'(coeff), 0);
            chk("zero_index", 32'(coeff_index), 32'(k - 1));
            chk("zero_done",  32'(done), (k == 256) ? 1 : 0);
        end
        chk("zero_fail",     32'(fail), 0);
        chk("zero_busy_end", 32'(busy), 0);
        tick();
        chk("zero_valid_after", 32'(coeff_valid), 0);
        chk("zero_idle_done",   32'(done), 0);
        tick();

        // ---- all-ones input: no accepts, fail at E0+448 ----
        in_string = '1;
        enable    = 1'b1;
        tick();                                   // E0
        enable    = 1'b0;
        vcnt      = 0;
        for (int k = 1; k <= 448; k++) begin
            tick();
            vcnt += int'(coeff_valid);
            if (k == 447) chk("ones_done_early", 32'(done), 0);
        end
        chk("ones_valid_cnt", 32'(vcnt), 0);
        chk("ones_done",      32'(done), 1);
        chk("ones_fail",      32'(fail), 1);
        tick();
        chk("ones_idle_done", 32'(done), 0);
        chk("ones_idle_fail", 32'(fail), 0);
        tick();

        // ---- boundary: 3328 accepted, 3329 rejected, rest 5 ----
        for (int i = 0; i < IN_BITS / 12; i++) begin
            in_string[12*i +: 12] = (i == 0) ? 12'hD00 : (i == 1) ? 12'hD01 : 12'h005;
        end
        enable = 1'b1;
        tick();                                   // E0
        enable = 1'b0;
        in_string = '1;                           // must be ignored during RUN
        tick();
        chk("bnd_valid0", 32'(coeff_valid), 1);
        chk("bnd_coeff0", 32'(coeff), 3328);
        chk("bnd_index0", 32'(coeff_index), 0);
        tick();
        chk("bnd_valid1", 32'(coeff_valid), 0);
        chk("bnd_hold_coeff", 32'(coeff), 3328);
        chk("bnd_hold_index", 32'(coeff_index), 0);
        tick();
        chk("bnd_valid2", 32'(coeff_valid), 1);
        chk("bnd_coeff2", 32'(coeff), 5);
        chk("bnd_index2", 32'(coeff_index), 1);
        vcnt = 2;
        for (int k = 4; k <= 257; k++) begin
            tick();
            vcnt += int'(coeff_valid);
            if (k == 256) chk("bnd_done_early", 32'(done), 0);
        end
        chk("bnd_valid_cnt", 32'(vcnt), 256);
        chk("bnd_done",      32'(done), 1);
        chk("bnd_fail",      32'(fail), 0);
        chk("bnd_index_end", 32'(coeff_index), 255);
        chk("bnd_coeff_end", 32'(coeff), 5);
        tick();
        tick();

        // ---- alternating 0xFFF / 0x001: 224 accepts, fail ----
        for (int i = 0; i < IN_BITS / 12; i++) begin
            in_string[12*i +: 12] = (i % 2 == 0) ? 12'hFFF : 12'h001;
        end
        enable = 1'b1;
        tick();                                   // E0
        enable = 1'b0;
        tick();
        chk("alt_valid0", 32'(coeff_valid), 0);
        tick();
        chk("alt_valid1", 32'(coeff_valid), 1);
        chk("alt_coeff1", 32'(coeff), 1);
        chk("alt_index1", 32'(coeff_index), 0);
        vcnt = 1;
        for (int k = 3; k <= 448; k++) begin
            tick();
            vcnt += int'(coeff_valid);
            if (k == 3)   chk("alt_valid2", 32'(coeff_valid), 0);
            if (k == 447) chk("alt_done_early", 32'(done), 0);
        end
        chk("alt_valid_cnt", 32'(vcnt), 224);
        chk("alt_index_end", 32'(coeff_index), 223);
        chk("alt_done",      32'(done), 1);
        chk("alt_fail",      32'(fail), 1);
        tick();
        tick();

        // ---- enable held high across completion, then restart ----
        in_string = '0;
        enable    = 1'b1;
        tick();                                   // E0
        for (int k = 1; k <= 256; k++) tick();
        chk("hold_done",  32'(done), 1);
        chk("hold_fail",  32'(fail), 0);
        chk("hold_index", 32'(coeff_index), 255);
        vcnt = 0;
        bcnt = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            vcnt += int'(coeff_valid);
            bcnt += int'(busy);
        end
        chk("hold_no_rerun_valid", 32'(vcnt), 0);
        chk("hold_no_rerun_busy",  32'(bcnt), 0);
        chk("hold_done_persist",   32'(done), 1);
        enable = 1'b0;
        tick();
        chk("hold_idle_done", 32'(done), 0);
        chk("hold_idle_busy", 32'(busy), 0);
        enable = 1'b1;
        tick();                                   // new E0
        chk("rerun_busy", 32'(busy), 1);
        for (int k = 1; k <= 99; k++) begin
            tick();
            if (k == 1) begin
                chk("rerun_valid0", 32'(coeff_valid), 1);
                chk("rerun_index0", 32'(coeff_index), 0);
            end
        end
        chk("rerun_index98", 32'(coeff_index), 98);

        // ---- reset at E0+100 mid-run ----
        rst    = 1'b1;
        enable = 1'b0;
        tick();                                   // E0+100
        chk("mrst_busy",  32'(busy), 0);
        chk("mrst_valid", 32'(coeff_valid), 0);
        chk("mrst_index", 32'(coeff_index), 0);
        chk("mrst_coeff", 32'(coeff), 0);
        chk("mrst_done",  32'(done), 0);
        rst  = 1'b0;
        vcnt = 0;
        bcnt = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            vcnt += int'(coeff_valid);
            bcnt += int'(busy);
        end
        chk("mrst_quiet_valid", 32'(vcnt), 0);
        chk("mrst_quiet_busy",  32'(bcnt), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
